z2_cycle_fsm: RTL
=================

Name: z2_cycle_fsm

Overview:
- Zorro II bus-cycle tracker and DTACK generator. It sits directly upstream of the autoconfig/decode block.
- Synchronises the 68000 strobes (AS_n, UDS_n, LDS_n) into CLK and produces the z2_state code that the decode block samples.
- Merges the per-target ready pulses (autoconfig dtack, RAM, flash, IDE) into one card-level DTACK and data-bus output enable.
- Includes a watchdog so a selected but silent target can never hang the bus.

Parameters:
- TIMEOUT_CYCLES, 64: CLK cycles in Z2_DATA without slave_ready before a forced DTACK; range 2..255.
- WAIT_CYCLES, 2: extra CLK cycles inserted between slave_ready and DTACK. Used only with Z2_WAITSTATE_EN; range 0..15.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- AS_n  in  1  68000 address strobe, asynchronous to CLK.
- UDS_n  in  1  upper data strobe, asynchronous.
- LDS_n  in  1  lower data strobe, asynchronous.
- RW  in  1  read(1)/write(0); sampled with the synchronised strobes.
- select  in  1  OR of the decode block's ram/ide/ctrl/flash/autoconfig access terms.
- slave_ready  in  1  OR of target ready signals; pulse or level.
- z2_state  out  2  Z2_IDLE=2'b00, Z2_START=2'b01, Z2_DATA=2'b10, Z2_END=2'b11.
- addr_latch  out  1  one-cycle pulse on entry to Z2_START.
- dtack_oe  out  1  drive DTACK_n low (open-drain enable).
- data_oe  out  1  enable card data-bus drivers.
- timeout  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (synchronous, RESET=1 at a CLK edge):
  - z2_state=Z2_IDLE; addr_latch=0, dtack_oe=0, data_oe=0, timeout=0.
  - All synchroniser flops=1; watchdog and wait counters=0; sticky ready flag=0.
  - RESET asserted mid-cycle aborts immediately to the same values, regardless of the strobes.
- Synchronisers:
  - Two flops per strobe; the strobe outputs are as_s, uds_s and lds_s.
  - ds_s = !(uds_s & lds_s), active-high.
  - A one-flop history of as_s gives as_fall = as_prev & !as_s.
  - RW is registered in parallel with the second sync stage.
- Z2_IDLE: as_fall -> Z2_START. A level-low AS without a seen edge (e.g. after reset) is ignored until AS rises and falls again.
- Z2_START: addr_latch=1 for exactly this state's first cycle. Transitions, first match wins:
  - as_s=1 (aborted cycle) -> Z2_END.
  - ds_s=1 -> Z2_DATA.
  - Otherwise stay.
- Z2_DATA:
  - Stay while as_s=0; as_s=1 -> Z2_END.
  - slave_ready seen while select=1 sets the sticky ready flag. It is set at most once per cycle; later pulses are ignored.
  - dtack_oe goes to 1 on the cycle after the flag sets (WAIT_CYCLES applies only with Z2_WAITSTATE_EN). It holds until exit from Z2_DATA.
  - data_oe = select & RW_s, registered; asserted from the first Z2_DATA cycle.
  - Watchdog: 8-bit counter, increments each Z2_DATA cycle while select=1 and the flag is clear.
    - Reaching TIMEOUT_CYCLES: pulse timeout and force the flag. dtack_oe then follows as above.
    - The counter saturates and does not wrap.
  - select=0: dtack_oe, data_oe and the watchdog stay 0; another card or chip RAM answers.
- Z2_END:
  - dtack_oe=0 and data_oe=0 on entry.
  - Clear the flag and the counters.
  - Unconditionally -> Z2_IDLE next cycle.
- Simultaneous events:
  - as_s rising in the same cycle the flag sets: exit wins, no DTACK asserted.
  - slave_ready together with the watchdog terminal count: no timeout pulse.
- Back-to-back cycles: after Z2_END, an AS fall is detected one cycle later. The minimum AS-high time of 68000 timing is always longer than this.

Optional Feature:
- Z2_WAITSTATE_EN defined:
  - After the flag sets, a 4-bit counter loads WAIT_CYCLES. dtack_oe asserts when it reaches 0, i.e. WAIT_CYCLES+1 cycles after the flag.
  - Exit from Z2_DATA while counting: abandon, no DTACK.
- Z2_WAITSTATE_EN undefined:
  - The wait counter is absent and WAIT_CYCLES is ignored.
  - dtack_oe asserts 1 cycle after the flag.

Test Plan:
- Read, select=1, slave_ready pulse 3 cycles after Z2_DATA entry:
  - z2_state runs 00→01→10→11→00.
  - addr_latch is a single 1-cycle pulse.
  - dtack_oe rises the cycle after the pulse and falls on Z2_END.
  - data_oe=1 throughout Z2_DATA.
- Write, select=1: data_oe stays 0 for the whole cycle; dtack_oe behaves as in the read case.
- select=1, slave_ready never asserted, TIMEOUT_CYCLES=64:
  - timeout pulses once at Z2_DATA cycle 64; dtack_oe follows 1 cycle later.
  - Counter holds at 64 until AS rises.
- select=0 full cycle: dtack_oe=0, data_oe=0 and timeout=0 throughout; z2_state still sequences.
- AS_n rises during Z2_START (DS never asserted): 01→11→00 with no dtack_oe. RESET pulse mid-Z2_DATA: all outputs 0 the next cycle, state 00.
- Z2_WAITSTATE_EN, WAIT_CYCLES=2: dtack_oe rises 3 cycles after slave_ready. With WAIT_CYCLES=0 it rises after 1 cycle. With WAIT_CYCLES=2 and AS rising 2 cycles after slave_ready, dtack_oe stays 0.

Source files
------------

// File: rtl/z2_cycle_fsm_if.sv
// Zorro II cycle-tracker bus bundle: 68000 strobes and target ready in, cycle state and DTACK/data enables out.
interface z2_cycle_fsm_if;
    logic       AS_n;
    logic       UDS_n;
    logic       LDS_n;
    logic       RW;
    logic       select;
    logic       slave_ready;
    logic [1:0] z2_state;
    logic       addr_latch;
    logic       dtack_oe;
    logic       data_oe;
    logic       timeout;

    modport master (
        output AS_n, UDS_n, LDS_n, RW, select, slave_ready,
        input  z2_state, addr_latch, dtack_oe, data_oe, timeout
    );

    modport slave (
        input  AS_n, UDS_n, LDS_n, RW, select, slave_ready,
        output z2_state, addr_latch, dtack_oe, data_oe, timeout
    );
endinterface

// File: rtl/z2_cycle_fsm.sv
// Zorro II bus-cycle tracker, card DTACK generator and watchdog.
// Optional Z2_WAITSTATE_EN inserts WAIT_CYCLES extra cycles between the ready flag and DTACK.
module z2_cycle_fsm #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned WAIT_CYCLES    = 2
) (
    input logic           CLK,
    input logic           RESET,
    z2_cycle_fsm_if.slave bus
);
    localparam int unsigned WDOG_W = 8;
    localparam int unsigned WAIT_W = 4;

    typedef enum logic [1:0] {
        Z2_IDLE  = 2'b00,
        Z2_START = 2'b01,
        Z2_DATA  = 2'b10,
        Z2_END   = 2'b11
    } z2_state_t;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255 || WAIT_CYCLES > 15) begin : g_param_err
        $error("z2_cycle_fsm: parameter out of range");
    end

    z2_state_t           state;
    logic                as_m, as_s, as_prev;
    logic                uds_m, uds_s, lds_m, lds_s;
    logic                rw_m, rw_s;
    logic [1:0]          sync_v;
    logic                as_armed;
    logic                flag;
    logic [WDOG_W-1:0]   wdog;
    logic                addr_latch, dtack_oe, data_oe, timeout;
`ifdef Z2_WAITSTATE_EN
    logic [WAIT_W-1:0]   wcnt;
    logic                wait_run;
`endif

    logic ds_s_c, as_fall_c, ready_hit_c;

    // A fall only counts once a genuine high AS has passed through the synchroniser since reset.
    assign ds_s_c      = !(uds_s & lds_s);
    assign as_fall_c   = as_armed & as_prev & !as_s;
    assign ready_hit_c = bus.select & !flag &
                         (bus.slave_ready | (wdog == WDOG_W'(TIMEOUT_CYCLES)));

    assign bus.z2_state   = state;
    assign bus.addr_latch = addr_latch;
    assign bus.dtack_oe   = dtack_oe;
    assign bus.data_oe    = data_oe;
    assign bus.timeout    = timeout;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= Z2_IDLE;
            as_m       <= 1'b1;
            as_s       <= 1'b1;
            as_prev    <= 1'b1;
            uds_m      <= 1'b1;
            uds_s      <= 1'b1;
            lds_m      <= 1'b1;
            lds_s      <= 1'b1;
            rw_m       <= 1'b1;
            rw_s       <= 1'b1;
            sync_v     <= 2'b00;
            as_armed   <= 1'b0;
            flag       <= 1'b0;
            wdog       <= '0;
            addr_latch <= 1'b0;
            dtack_oe   <= 1'b0;
            data_oe    <= 1'b0;
            timeout    <= 1'b0;
`ifdef Z2_WAITSTATE_EN
            wcnt       <= '0;
            wait_run   <= 1'b0;
`endif
        end else begin
            as_m    <= bus.AS_n;
            as_s    <= as_m;
            as_prev <= as_s;
            uds_m   <= bus.UDS_n;
            uds_s   <= uds_m;
            lds_m   <= bus.LDS_n;
            lds_s   <= lds_m;
            rw_m    <= bus.RW;
            rw_s    <= rw_m;
            sync_v  <= {sync_v[0], 1'b1};
            if (sync_v[1] && as_s) as_armed <= 1'b1;

            addr_latch <= 1'b0;
            timeout    <= 1'b0;

            case (state)
                Z2_IDLE: begin
                    if (as_fall_c) begin
                        state      <= Z2_START;
                        addr_latch <= 1'b1;
                    end
                end
                Z2_START: begin
                    if (as_s) begin
                        state <= Z2_END;
                    end else if (ds_s_c) begin
                        state   <= Z2_DATA;
                        data_oe <= bus.select & rw_s;
                    end
                end
                Z2_DATA: begin
                    if (as_s) begin
                        state    <= Z2_END;
                        dtack_oe <= 1'b0;
                        data_oe  <= 1'b0;
                    end else begin
                        data_oe <= bus.select & rw_s;
                        if (ready_hit_c) begin
                            flag <= 1'b1;
`ifdef Z2_WAITSTATE_EN
                            if (WAIT_CYCLES == 0) begin
                                dtack_oe <= 1'b1;
                            end else begin
                                wcnt     <= WAIT_W'(WAIT_CYCLES);
                                wait_run <= 1'b1;
                            end
`else
                            dtack_oe <= 1'b1;
`endif
                        end else if (bus.select && !flag && wdog != {WDOG_W{1'b1}}) begin
                            wdog <= wdog + WDOG_W'(1);
                            if (wdog + WDOG_W'(1) == WDOG_W'(TIMEOUT_CYCLES)) timeout <= 1'b1;
                        end
`ifdef Z2_WAITSTATE_EN
                        if (wait_run) begin
                            wcnt <= wcnt - WAIT_W'(1);
                            if (wcnt == WAIT_W'(1)) begin
                                dtack_oe <= 1'b1;
                                wait_run <= 1'b0;
                            end
                        end
`endif
                    end
                end
                Z2_END: begin
                    state    <= Z2_IDLE;
                    flag     <= 1'b0;
                    wdog     <= '0;
                    dtack_oe <= 1'b0;
                    data_oe  <= 1'b0;
`ifdef Z2_WAITSTATE_EN
                    wcnt     <= '0;
                    wait_run <= 1'b0;
`endif
                end
                default: state <= Z2_IDLE;
            endcase
        end
    end
endmodule
